// File: rtl/ppu_requant_if.sv
// Bundles the ppu_requant data, parameter and RAM-port signals into one bus.
// master drives the i_* side (host/bench); slave is the PPU itself.
interface ppu_requant_if #(
   parameter int LANES = 16,
   parameter int ACC_W = 24,
   parameter int COLS  = 64
);
   localparam int AW = $clog2(COLS);
   localparam int KW = $clog2(LANES);

   logic                     i_ppu_start;
   logic [LANES*ACC_W-1:0]   i_acc_data;
   logic                     i_relu_en;
   logic                     i_param_we;
   logic                     i_param_sel;
   logic [KW-1:0]            i_param_addr;
   logic [LANES*16-1:0]      i_param_data;
   logic [AW-1:0]            i_rd_addr;
   logic [LANES*4-1:0]       o_rd_data;
   logic                     o_ram_we;
   logic [LANES*4-1:0]       o_ram_data;
   logic [AW-1:0]            o_ram_addr;
   logic [LANES*18-1:0]      o_vsq_sf;
   logic [17:0]              o_int4_sf;
   logic                     o_finish;

   modport master (
      output i_ppu_start, i_acc_data, i_relu_en, i_param_we, i_param_sel,
             i_param_addr, i_param_data, i_rd_addr,
      input  o_rd_data, o_ram_we, o_ram_data, o_ram_addr, o_vsq_sf,
             o_int4_sf, o_finish
   );

   modport slave (
      input  i_ppu_start, i_acc_data, i_relu_en, i_param_we, i_param_sel,
             i_param_addr, i_param_data, i_rd_addr,
      output o_rd_data, o_ram_we, o_ram_data, o_ram_addr, o_vsq_sf,
             o_int4_sf, o_finish
   );
endinterface

// File: rtl/ppu_requant.sv
// Post-processing unit: scale/bias/ReLU, per-row VSQ shift, INT4 requant into a 64x64 RAM.
// Optional macro PPU_INT8_SF_EN adds the o_int8_sf output.
module ppu_requant #(
   parameter int LANES = 16,
   parameter int ACC_W = 24,
   parameter int COLS  = 64,
   parameter int FRAC  = 10
) (
   input  logic               i_clk,
   input  logic               i_rst,
   ppu_requant_if.slave       bus
`ifdef PPU_INT8_SF_EN
   ,
   output logic [17:0]        o_int8_sf
`endif
);
   localparam int Y_W = 18;
   localparam int P_W = ACC_W + 16;
   localparam int AW  = $clog2(COLS);
   localparam int KW  = $clog2(LANES);
   localparam logic signed [P_W:0] SAT_HI = (P_W+1)'(131071);
   localparam logic signed [P_W:0] SAT_LO = -(P_W+1)'(131072);

   typedef enum logic [2:0] {IDLE, RECV, WAIT, CALC, DRAIN, DONE} state_e;

   state_e                    state_q;
   logic [1:0]                tile_q;
   logic [KW-1:0]             vec_q;
   logic [AW-1:0]             col_q;
   logic                      finish_q;
   logic [Y_W-1:0]            m_q      [LANES];
   logic [3:0]                vsq_sf_q [LANES];
   logic [3:0]                int4_sf_q;
   logic signed [15:0]        scale_q  [LANES][LANES];
   logic signed [15:0]        bias_q   [LANES][LANES];
   logic signed [Y_W-1:0]     ybuf_q   [COLS][LANES];
   logic [LANES*4-1:0]        ram_q    [COLS];
   logic [LANES*4-1:0]        rd_data_q;

   logic signed [Y_W-1:0]     y_d      [LANES];
   logic [Y_W-1:0]            mag_d    [LANES];
   logic [3:0]                vsq_sf_d [LANES];
   logic [3:0]                int4_sf_d;
   logic [LANES*4-1:0]        ram_data_d;
   logic                      ram_we;

   function automatic logic [4:0] bit_len(input logic [Y_W-1:0] v);
      bit_len = '0;
      for (int i = 0; i < Y_W; i++)
         if (v[i]) bit_len = 5'(i + 1);
   endfunction

   // Per-lane element arithmetic for the vector currently on the bus.
   always_comb begin : elem_math
      logic signed [ACC_W-1:0] acc_l;
      logic signed [P_W-1:0]   prod;
      logic signed [P_W:0]     sum;
      // NOTE: every temporary gets a value before any path reads it, so no latch is inferred.
      acc_l = '0;
      prod  = '0;
      sum   = '0;
      for (int j = 0; j < LANES; j++) begin
         acc_l = bus.i_acc_data[ACC_W*j +: ACC_W];
         prod  = P_W'(acc_l) * P_W'(scale_q[vec_q][j]);
         sum   = (P_W+1)'(prod >>> FRAC) + (P_W+1)'(bias_q[vec_q][j]);
         if (bus.i_relu_en && sum < 0) sum = '0;
         if (sum > SAT_HI)      sum = SAT_HI;
         else if (sum < SAT_LO) sum = SAT_LO;
         y_d[j]   = sum[Y_W-1:0];
         mag_d[j] = y_d[j][Y_W-1] ? unsigned'(-y_d[j]) : unsigned'(y_d[j]);
      end
   end

   always_comb begin : shift_calc
      logic [4:0] bl;
      bl        = '0;
      int4_sf_d = '0;
      for (int j = 0; j < LANES; j++) begin
         bl          = bit_len(m_q[j]);
         vsq_sf_d[j] = (bl > 5'd3) ? 4'(bl - 5'd3) : 4'd0;
         if (vsq_sf_d[j] > int4_sf_d) int4_sf_d = vsq_sf_d[j];
      end
   end

`ifdef PPU_INT8_SF_EN
   logic [3:0] int8_sf_q;
   logic [3:0] int8_sf_d;

   always_comb begin : int8_calc
      logic [Y_W-1:0] mmax;
      logic [4:0]     bl8;
      mmax = '0;
      for (int j = 0; j < LANES; j++)
         if (m_q[j] > mmax) mmax = m_q[j];
      bl8       = bit_len(mmax);
      int8_sf_d = (bl8 > 5'd7) ? 4'(bl8 - 5'd7) : 4'd0;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst)                                   int8_sf_q <= '0;
      else if (state_q == IDLE && bus.i_ppu_start) int8_sf_q <= '0;
      else if (state_q == CALC)                    int8_sf_q <= int8_sf_d;
   end

   assign o_int8_sf = 18'(int8_sf_q);
`endif

   // Arithmetic shift by the row factor, then clamp into the INT4 range.
   always_comb begin : requant
      logic signed [Y_W-1:0] sh;
      sh         = '0;
      ram_data_d = '0;
      for (int j = 0; j < LANES; j++) begin
         sh = ybuf_q[col_q][j] >>> vsq_sf_q[j];
         if (sh > 18'sd7)        ram_data_d[4*j +: 4] = 4'h7;
         else if (sh < -18'sd8)  ram_data_d[4*j +: 4] = 4'h8;
         else                    ram_data_d[4*j +: 4] = sh[3:0];
      end
   end

   assign ram_we = (state_q == DRAIN);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= IDLE;
         tile_q    <= '0;
         vec_q     <= '0;
         col_q     <= '0;
         finish_q  <= 1'b0;
         int4_sf_q <= '0;
         for (int j = 0; j < LANES; j++) begin
            m_q[j]      <= '0;
            vsq_sf_q[j] <= '0;
         end
      end else begin
         finish_q <= (state_q == DRAIN) && (col_q == AW'(COLS - 1));
         unique case (state_q)
            IDLE: if (bus.i_ppu_start) begin
               state_q   <= RECV;
               tile_q    <= '0;
               vec_q     <= '0;
               int4_sf_q <= '0;
               for (int j = 0; j < LANES; j++) begin
                  m_q[j]      <= '0;
                  vsq_sf_q[j] <= '0;
               end
            end
            RECV: begin
               vec_q <= vec_q + 1'b1;
               for (int j = 0; j < LANES; j++)
                  if (mag_d[j] > m_q[j]) m_q[j] <= mag_d[j];
               if (vec_q == KW'(LANES - 1)) begin
                  tile_q  <= tile_q + 1'b1;
                  state_q <= (tile_q == 2'd3) ? CALC : WAIT;
               end
            end
            WAIT: if (bus.i_ppu_start) begin
               state_q <= RECV;
               vec_q   <= '0;
            end
            CALC: begin
               for (int j = 0; j < LANES; j++) vsq_sf_q[j] <= vsq_sf_d[j];
               int4_sf_q <= int4_sf_d;
               col_q     <= '0;
               state_q   <= DRAIN;
            end
            DRAIN: begin
               col_q <= col_q + 1'b1;
               if (col_q == AW'(COLS - 1)) state_q <= DONE;
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int k = 0; k < LANES; k++)
            for (int j = 0; j < LANES; j++) begin
               scale_q[k][j] <= 16'sh0400;
               bias_q[k][j]  <= '0;
            end
      end else if (bus.i_param_we) begin
         for (int j = 0; j < LANES; j++) begin
            if (bus.i_param_sel) bias_q[bus.i_param_addr][j]  <= bus.i_param_data[16*j +: 16];
            else                 scale_q[bus.i_param_addr][j] <= bus.i_param_data[16*j +: 16];
         end
      end
   end

   // NOTE: the staging buffer has no reset; every column is rewritten during RECV before DRAIN reads it.
   always_ff @(posedge i_clk) begin
      if (state_q == RECV)
         for (int j = 0; j < LANES; j++) ybuf_q[{tile_q, vec_q}][j] <= y_d[j];
   end

   // Output RAM: cleared by reset, read-before-write on a same-address collision.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int a = 0; a < COLS; a++) ram_q[a] <= '0;
         rd_data_q <= '0;
      end else begin
         if (ram_we) ram_q[col_q] <= ram_data_d;
         rd_data_q <= ram_q[bus.i_rd_addr];
      end
   end

   always_comb begin
      bus.o_vsq_sf = '0;
      for (int j = 0; j < LANES; j++) bus.o_vsq_sf[18*j +: 18] = 18'(vsq_sf_q[j]);
   end

   assign bus.o_rd_data  = rd_data_q;
   assign bus.o_ram_we   = ram_we;
   assign bus.o_ram_data = ram_we ? ram_data_d : '0;
   assign bus.o_ram_addr = ram_we ? col_q : '0;
   assign bus.o_int4_sf  = 18'(int4_sf_q);
   assign bus.o_finish   = finish_q;
endmodule

// File: tb/tb_ppu_requant.sv
// Scoreboard bench for ppu_requant: reference model fills a queue of expected RAM writes.
module tb_ppu_requant;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ppu_requant_if bus ();
`ifdef PPU_INT8_SF_EN
   logic [17:0] int8_sf;
`endif

   ppu_requant dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
`ifdef PPU_INT8_SF_EN
      ,
      .o_int8_sf (int8_sf)
`endif
   );

   typedef struct packed {
      logic [5:0]  addr;
      logic [63:0] data;
   } wr_t;

   wr_t         exp_q[$];
   int          total = 0;
   int          bad   = 0;
   int          acc_m   [64][16];
   int          scale_m [16][16];
   int          bias_m  [16][16];
   bit          relu_m;
   longint      y_m     [64][16];
   int          sf_m    [16];
   int          int4_m;
   int          int8_m;
   logic [63:0] word_m  [64];

   function automatic int bitlen(longint v);
      int b = 0;
      while (v > 0) begin
         b++;
         v = v >>> 1;
      end
      return b;
   endfunction

   // Reference model of the whole job from the bench's own stimulus arrays.
   task automatic build_model();
      longint p, y, mx;
      longint m [16];
      for (int j = 0; j < 16; j++) m[j] = 0;
      for (int c = 0; c < 64; c++)
         for (int j = 0; j < 16; j++) begin
            p = longint'(acc_m[c][j]) * longint'(scale_m[c % 16][j]);
            y = (p >>> 10) + longint'(bias_m[c % 16][j]);
            if (relu_m && y < 0) y = 0;
            if (y > 131071) y = 131071;
            if (y < -131072) y = -131072;
            y_m[c][j] = y;
            if ((y < 0 ? -y : y) > m[j]) m[j] = (y < 0 ? -y : y);
         end
      int4_m = 0;
      mx = 0;
      for (int j = 0; j < 16; j++) begin
         sf_m[j] = (bitlen(m[j]) > 3) ? bitlen(m[j]) - 3 : 0;
         if (sf_m[j] > int4_m) int4_m = sf_m[j];
         if (m[j] > mx) mx = m[j];
      end
      int8_m = (bitlen(mx) > 7) ? bitlen(mx) - 7 : 0;
      for (int c = 0; c < 64; c++)
         for (int j = 0; j < 16; j++) begin
            y = y_m[c][j] >>> sf_m[j];
            if (y > 7) y = 7;
            if (y < -8) y = -8;
            word_m[c][4*j +: 4] = 4'(y);
         end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      for (int k = 0; k < 16; k++)
         for (int j = 0; j < 16; j++) begin
            scale_m[k][j] = 1024;
            bias_m[k][j]  = 0;
         end
   endtask

   task automatic set_all(input bit sel, input int value);
      for (int k = 0; k < 16; k++) begin
         bus.i_param_we   = 1'b1;
         bus.i_param_sel  = sel;
         bus.i_param_addr = 4'(k);
         for (int j = 0; j < 16; j++) begin
            bus.i_param_data[16*j +: 16] = 16'(value);
            if (sel) bias_m[k][j] = value;
            else     scale_m[k][j] = value;
         end
         @(negedge clk);
      end
      bus.i_param_we = 1'b0;
   endtask

   task automatic fill_acc(input int value);
      for (int c = 0; c < 64; c++)
         for (int j = 0; j < 16; j++) acc_m[c][j] = value;
   endtask

   // Drive four tiles, queue the expected writes, then score the DUT's drain and outputs.
   task automatic drive_and_score(input string name, input bit stray);
      int fin = 0, writes = 0;
      bit done = 0;
      wr_t e;
      int rd_list [4];
      relu_m = bus.i_relu_en;
      for (int t = 0; t < 4; t++) begin
         bus.i_ppu_start = 1'b1;
         @(negedge clk);
         for (int k = 0; k < 16; k++) begin
            bus.i_ppu_start = (stray && t == 1 && k == 4);
            for (int j = 0; j < 16; j++)
               bus.i_acc_data[24*j +: 24] = 24'(acc_m[t*16+k][j]);
            @(negedge clk);
         end
         bus.i_ppu_start = 1'b0;
      end
      build_model();
      for (int c = 0; c < 64; c++) exp_q.push_back('{addr: 6'(c), data: word_m[c]});
      for (int cyc = 0; cyc < 200 && !done; cyc++) begin
         if (bus.o_ram_we) begin
            writes++;
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL %s extra_write addr=%0d data=%h want none", name, bus.o_ram_addr, bus.o_ram_data);
            end else begin
               e = exp_q.pop_front();
               if (bus.o_ram_addr !== e.addr || bus.o_ram_data !== e.data) begin
                  bad++;
                  $display("FAIL %s ram_write got addr=%0d data=%h want addr=%0d data=%h",
                           name, bus.o_ram_addr, bus.o_ram_data, e.addr, e.data);
               end
            end
         end
         if (bus.o_finish) begin
            fin++;
            done = 1;
         end else begin
            @(negedge clk);
         end
      end
      total++;
      if (!done || writes !== 64 || exp_q.size() !== 0) begin
         bad++;
         $display("FAIL %s completion got finish=%0d writes=%0d left=%0d want finish=1 writes=64 left=0",
                  name, fin, writes, exp_q.size());
      end
      exp_q.delete();
      @(negedge clk);
      total++;
      if (bus.o_finish !== 1'b0) begin
         bad++;
         $display("FAIL %s finish_width got=%b want=0", name, bus.o_finish);
      end
      for (int j = 0; j < 16; j++) begin
         total++;
         if (bus.o_vsq_sf[18*j +: 18] !== 18'(sf_m[j])) begin
            bad++;
            $display("FAIL %s vsq_sf[%0d] got=%0d want=%0d", name, j, bus.o_vsq_sf[18*j +: 18], sf_m[j]);
         end
      end
      total++;
      if (bus.o_int4_sf !== 18'(int4_m)) begin
         bad++;
         $display("FAIL %s int4_sf got=%0d want=%0d", name, bus.o_int4_sf, int4_m);
      end
`ifdef PPU_INT8_SF_EN
      total++;
      if (int8_sf !== 18'(int8_m)) begin
         bad++;
         $display("FAIL %s int8_sf got=%0d want=%0d", name, int8_sf, int8_m);
      end
`endif
      rd_list = '{0, 37, 63, $urandom_range(1, 62)};
      foreach (rd_list[i]) begin
         bus.i_rd_addr = 6'(rd_list[i]);
         @(negedge clk);
         total++;
         if (bus.o_rd_data !== word_m[rd_list[i]]) begin
            bad++;
            $display("FAIL %s rd[%0d] got=%h want=%h", name, rd_list[i], bus.o_rd_data, word_m[rd_list[i]]);
         end
      end
   endtask

   task automatic test_reset();
      apply_reset();
      bus.i_rd_addr = 6'd5;
      @(negedge clk);
      total++;
      if (bus.o_vsq_sf !== '0 || bus.o_int4_sf !== '0 || bus.o_finish !== 1'b0 ||
          bus.o_ram_we !== 1'b0 || bus.o_ram_addr !== '0 || bus.o_ram_data !== '0) begin
         bad++;
         $display("FAIL reset_outputs got sf=%h int4=%0d fin=%b we=%b addr=%0d data=%h want all 0",
                  bus.o_vsq_sf, bus.o_int4_sf, bus.o_finish, bus.o_ram_we, bus.o_ram_addr, bus.o_ram_data);
      end
      total++;
      if (bus.o_rd_data !== 64'h0) begin
         bad++;
         $display("FAIL reset_ram got=%h want=0", bus.o_rd_data);
      end
   endtask

   task automatic test_uniform();
      fill_acc(5);
      drive_and_score("uniform", 1'b0);
   endtask

   task automatic test_single_peak();
      fill_acc(1);
      acc_m[37][0] = 100;
      drive_and_score("single_peak", 1'b0);
   endtask

   task automatic test_scale_half();
      set_all(1'b0, 16'h0200);
      fill_acc(-20);
      drive_and_score("scale_half", 1'b0);
   endtask

   task automatic test_relu();
      set_all(1'b0, 16'h0400);
      bus.i_relu_en = 1'b1;
      fill_acc(-3);
      drive_and_score("relu", 1'b0);
      bus.i_relu_en = 1'b0;
   endtask

   task automatic test_bias_mixed();
      set_all(1'b1, 3);
      for (int c = 0; c < 64; c++)
         for (int j = 0; j < 16; j++) acc_m[c][j] = ((c * 37 + j * 113) % 3001) - 1500;
      drive_and_score("bias_mixed", 1'b0);
      set_all(1'b1, 0);
   endtask

   task automatic test_saturate();
      fill_acc(8388607);
      drive_and_score("saturate", 1'b0);
   endtask

   task automatic test_abort_rerun();
      set_all(1'b0, 16'h0200);
      fill_acc(7);
      for (int t = 0; t < 3; t++) begin
         bus.i_ppu_start = 1'b1;
         @(negedge clk);
         for (int k = 0; k < ((t == 2) ? 7 : 16); k++) begin
            bus.i_ppu_start = (t == 0 && k == 3);
            for (int j = 0; j < 16; j++) bus.i_acc_data[24*j +: 24] = 24'(acc_m[t*16+k][j]);
            @(negedge clk);
         end
         bus.i_ppu_start = 1'b0;
      end
      bus.i_rd_addr = 6'd10;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      total++;
      if (bus.o_vsq_sf !== '0 || bus.o_int4_sf !== '0 || bus.o_ram_we !== 1'b0 ||
          bus.o_finish !== 1'b0 || bus.o_rd_data !== 64'h0) begin
         bad++;
         $display("FAIL abort_outputs got sf=%h int4=%0d we=%b fin=%b rd=%h want all 0",
                  bus.o_vsq_sf, bus.o_int4_sf, bus.o_ram_we, bus.o_finish, bus.o_rd_data);
      end
      for (int k = 0; k < 16; k++)
         for (int j = 0; j < 16; j++) begin
            scale_m[k][j] = 1024;
            bias_m[k][j]  = 0;
         end
      fill_acc(5);
      drive_and_score("rerun_after_abort", 1'b1);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog expired got=running want=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.i_ppu_start  = 1'b0;
      bus.i_acc_data   = '0;
      bus.i_relu_en    = 1'b0;
      bus.i_param_we   = 1'b0;
      bus.i_param_sel  = 1'b0;
      bus.i_param_addr = '0;
      bus.i_param_data = '0;
      bus.i_rd_addr    = '0;
      test_reset();
      test_uniform();
      test_single_peak();
      test_scale_half();
      test_relu();
      test_bias_mixed();
      test_saturate();
      test_abort_rerun();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
